ffe_scheduler: RTL and testbench
================================

Name: ffe_scheduler

Overview:
- Sequences the zero-crossing period measurement engine of the fundamental-frequency estimator.
- Each measurement is started by a start/done handshake with the engine.
- Out-of-range periods are rejected; a silent input is detected by timeout.
- 2^AVG_LOG2 accepted periods are averaged and the result goes to the octave-shift stage over a valid/ready handshake.

Parameters:
- WIDTH, 32, width of the period values in clock cycles.
- AVG_LOG2, 2, log2 of the number of accepted periods averaged per output.
- TIMEOUT, 1000000, number of WAIT cycles without meas_done before the block declares silence.
- MIN_PERIOD, 20, smallest accepted period (inclusive).
- MAX_PERIOD, 200000, largest accepted period (inclusive).

Ports:
- CLK_IN  input  1  system clock; the block has one clock.
- RST_N  input  1  asynchronous, active-low reset.
- enable  input  1  run request for the scheduler.
- meas_start  output  1  one-cycle pulse that arms one engine measurement.
- meas_done  input  1  one-cycle pulse from the engine: meas_periodo is valid.
- meas_periodo  input  WIDTH  measured period in clock cycles.
- periodo  output  WIDTH  averaged period.
- periodo_valid  output  1  periodo is available.
- periodo_ready  input  1  the consumer accepts periodo.
- silence  output  1  set on timeout; cleared on the next delivered average.
- reject_count  output  8  saturating count of out-of-range samples.

Behaviour:
- Reset (asynchronous, RST_N low):
  - state=IDLE.
  - periodo, periodo_valid, meas_start, silence, reject_count, accumulator, sample counter and timer all reset to 0.
- Accumulator width is WIDTH+AVG_LOG2 and cannot overflow. Sample counter width is AVG_LOG2+1.
- All outputs are registered.
- IDLE:
  - If enable=1 -> START. Accumulator and sample counter are cleared.
  - meas_done is ignored in IDLE.
- START:
  - meas_start=1 for exactly this one cycle; timer cleared.
  - Next state is WAIT, or IDLE if enable=0.
- WAIT (timer increments every cycle):
  - meas_done=1: capture meas_periodo -> CHECK.
  - Else, when the timer reaches TIMEOUT-1: silence<=1, accumulator and sample counter cleared -> START (automatic retry).
  - If meas_done and timeout occur in the same cycle, meas_done wins.
  - enable=0 -> IDLE. The partial accumulation is discarded; a pending meas_done is ignored.
- CHECK:
  - Sample within [MIN_PERIOD, MAX_PERIOD]: the accumulator adds the sample and the sample counter increments.
    - If this was sample number 2^AVG_LOG2: periodo <= (accumulator+sample) >> AVG_LOG2 (truncating), periodo_valid<=1, silence<=0 -> OUTPUT.
    - Otherwise -> START.
  - Sample out of range: reject_count increments (saturates at 255), accumulator unchanged -> START.
  - enable=0 in CHECK -> IDLE, discard.
- OUTPUT:
  - periodo_valid is held high and periodo is held stable until periodo_ready=1.
  - No meas_start is issued while in OUTPUT.
  - enable is ignored until the handshake completes.
  - On the handshake cycle: periodo_valid<=0, accumulator and counter cleared, then -> START if enable=1, else IDLE.
  - periodo keeps its last value after valid drops.
- Latency: meas_done on the last accepted sample at edge k -> periodo_valid high after edge k+2.
- Minimum per-sample overhead is 3 cycles (START, WAIT, CHECK) plus the engine time.

Test Plan:
- AVG_LOG2=2, ready=1, samples 100,102,98,101 -> periodo=100 (401>>2), periodo_valid high 2 cycles after the 4th done, high for 1 cycle, exactly 4 meas_start pulses before it.
- Samples 100,10,100,300000,100,100 (MIN=20, MAX=200000) -> reject_count=2, periodo=100, 6 meas_start pulses in total.
- TIMEOUT=100, no meas_done -> silence=1 after 100 WAIT cycles; meas_start pulses again 1 cycle later; 4 valid samples of 50 -> periodo=50, silence returns to 0 with periodo_valid.
- periodo_ready held low 10 cycles after valid -> periodo_valid and periodo stay constant, no meas_start; ready=1 -> valid drops next edge, meas_start pulses the following cycle.
- Drop enable during WAIT after 2 accepted samples -> IDLE next cycle, late meas_done ignored; re-enable plus 4 samples of 200 -> periodo=200, not polluted by the old partial sum.
- Assert RST_N=0 mid-OUTPUT with periodo=100 -> periodo, periodo_valid, silence, reject_count and meas_start are 0 immediately, without waiting for a clock edge; after release the FSM is IDLE.

Source files
------------

// File: rtl/ffe_scheduler.sv
// Control FSM for the zero-crossing period engine. It arms one measurement at a time,
// drops out-of-range periods, averages the accepted ones and offers the result downstream.
module ffe_scheduler #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned MIN_PERIOD = 20,
  parameter int unsigned MAX_PERIOD = 200000
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             enable,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [WIDTH-1:0] meas_periodo,
  output logic [WIDTH-1:0] periodo,
  output logic             periodo_valid,
  input  logic             periodo_ready,
  output logic             silence,
  output logic [7:0]       reject_count
);

  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(2 ** AVG_LOG2 - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MIN_P    = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] MAX_P    = WIDTH'(MAX_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CHECK, S_OUTPUT
  } state_t;

  state_t           r_state, w_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [TMR_W-1:0] r_timer;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_periodo;
  logic             r_meas_start, r_valid, r_silence;
  logic [7:0]       r_reject;

  logic             w_in_range, w_clear, w_accept, w_reject;
  logic             w_deliver, w_timeout, w_capture;
  logic [ACC_W-1:0] w_sum;

  assign w_in_range = (r_sample >= MIN_P) && (r_sample <= MAX_P);
  assign w_sum      = r_acc + ACC_W'(r_sample);

  // NOTE: every signal written here is defaulted first so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_deliver = 1'b0;
    w_timeout = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_clear = 1'b1;
          w_next  = S_START;
        end
      end
      S_START: w_next = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        // Dropping enable beats a simultaneous done; done beats the timeout.
        if (!enable) begin
          w_next = S_IDLE;
        end else if (meas_done) begin
          w_capture = 1'b1;
          w_next    = S_CHECK;
        end else if (r_timer == TMR_LAST) begin
          w_timeout = 1'b1;
          w_clear   = 1'b1;
          w_next    = S_START;
        end
      end
      S_CHECK: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (w_in_range) begin
          w_accept = 1'b1;
          if (r_count == LAST_IDX) begin
            w_deliver = 1'b1;
            w_next    = S_OUTPUT;
          end else begin
            w_next = S_START;
          end
        end else begin
          w_reject = 1'b1;
          w_next   = S_START;
        end
      end
      S_OUTPUT: begin
        if (periodo_ready) begin
          w_clear = 1'b1;
          w_next  = enable ? S_START : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_acc        <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_sample     <= '0;
      r_periodo    <= '0;
      r_meas_start <= 1'b0;
      r_valid      <= 1'b0;
      r_silence    <= 1'b0;
      r_reject     <= '0;
    end else begin
      // Registered so the pulse lines up exactly with the START cycle.
      r_meas_start <= (w_next == S_START);

      if (r_state == S_START)     r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;

      if (w_capture) r_sample <= meas_periodo;

      if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= r_count + 1'b1;
      end

      if (w_reject && (r_reject != 8'hFF)) r_reject <= r_reject + 1'b1;

      if (w_deliver) begin
        r_periodo <= w_sum[ACC_W-1:AVG_LOG2];
        r_valid   <= 1'b1;
      end else if ((r_state == S_OUTPUT) && periodo_ready) begin
        r_valid <= 1'b0;
      end

      if (w_timeout)      r_silence <= 1'b1;
      else if (w_deliver) r_silence <= 1'b0;
    end
  end

  assign meas_start    = r_meas_start;
  assign periodo       = r_periodo;
  assign periodo_valid = r_valid;
  assign silence       = r_silence;
  assign reject_count  = r_reject;

endmodule

// File: tb/tb_ffe_scheduler.sv
// Bench for ffe_scheduler: a bench-side engine answers meas_start pulses with random
// periods while a sample-list model predicts averages, rejects and silence.
module tb_ffe_scheduler;

  localparam int W    = 32;
  localparam int AVG  = 2;
  localparam int TMO  = 100;
  localparam int MINP = 20;
  localparam int MAXP = 200000;
  localparam int START_BOUND = 4 * TMO + 200;

  logic         CLK_IN, RST_N, enable, meas_start, meas_done;
  logic [W-1:0] meas_periodo, periodo;
  logic         periodo_valid, periodo_ready, silence;
  logic [7:0]   reject_count;

  ffe_scheduler #(
    .WIDTH(W), .AVG_LOG2(AVG), .TIMEOUT(TMO), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
  ) dut (
    .CLK_IN       (CLK_IN),
    .RST_N        (RST_N),
    .enable       (enable),
    .meas_start   (meas_start),
    .meas_done    (meas_done),
    .meas_periodo (meas_periodo),
    .periodo      (periodo),
    .periodo_valid(periodo_valid),
    .periodo_ready(periodo_ready),
    .silence      (silence),
    .reject_count (reject_count)
  );

  // Reference model: accepted samples of the current group, averages still owed downstream.
  longint unsigned m_part[$];
  longint unsigned m_exp[$];
  int              m_rej;
  bit              m_silence;

  int n_checks, n_err, n_starts;
  bit rand_ready;

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  // Engine side of the model: what one returned period does to the expected outputs.
  task automatic model_sample(input logic [W-1:0] val, output bit last);
    longint unsigned v = val;
    longint unsigned s = 0;
    last = 1'b0;
    if (v >= MINP && v <= MAXP) begin
      m_part.push_back(v);
      if (m_part.size() == (1 << AVG)) begin
        foreach (m_part[i]) s += m_part[i];
        m_exp.push_back(s >> AVG);
        m_part.delete();
        m_silence = 1'b0;
        last = 1'b1;
      end
    end else if (m_rej < 255) begin
      m_rej++;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (meas_start !== 1'b1 && n < START_BOUND) begin
      @(negedge CLK_IN);
      n++;
    end
    if (meas_start !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_start: no meas_start within %0d cycles", START_BOUND);
      finish_run();
    end
  endtask

  // Answer the current measurement after `delay` WAIT cycles, then check the latency.
  task automatic feed(input logic [W-1:0] val, input int delay);
    bit last;
    wait_start();
    repeat (delay + 1) @(posedge CLK_IN);
    #1;
    meas_done    = 1'b1;
    meas_periodo = val;
    model_sample(val, last);
    @(posedge CLK_IN);
    #1;
    meas_done    = 1'b0;
    meas_periodo = $urandom;
    @(negedge CLK_IN);
    check("valid_before_latency", periodo_valid, 1'b0);
    @(negedge CLK_IN);
    if (last) check("valid_latency", periodo_valid, 1'b1);
    else      check("restart_latency", meas_start, 1'b1);
  endtask

  // Leave a measurement unanswered: the retry must come TMO+1 cycles after the last start.
  task automatic stay_silent();
    int n = 0;
    wait_start();
    @(posedge CLK_IN);
    #1;
    m_silence = 1'b1;
    m_part.delete();
    do begin
      @(negedge CLK_IN);
      n++;
    end while (meas_start !== 1'b1 && n < TMO + 20);
    check("timeout_gap", n, TMO + 1);
  endtask

  function automatic logic [W-1:0] rand_period();
    case ($urandom_range(0, 11))
      0:       return W'(MINP);
      1:       return W'(MAXP);
      2:       return W'(MINP - 1);
      3:       return W'(MAXP + 1);
      4:       return W'($urandom_range(0, MINP - 1));
      5:       return $urandom;
      default: return W'($urandom_range(MINP, MAXP));
    endcase
  endfunction

  // Compare process: output invariants every cycle, model values where they are defined.
  initial begin
    logic         pv, pr;
    logic [W-1:0] pp;
    pv = 1'b0;
    pr = 1'b0;
    pp = '0;
    forever begin
      @(negedge CLK_IN);
      if (RST_N !== 1'b1) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (meas_start === 1'b1) begin
          n_starts++;
          check("start_while_valid", periodo_valid, 1'b0);
          check("reject_count", reject_count, m_rej);
          check("silence_at_start", silence, m_silence);
        end
        if (pv) begin
          check("periodo_hold", periodo, pp);
          if (!pr) check("valid_hold", periodo_valid, 1'b1);
        end
        if (periodo_valid === 1'b1 && periodo_ready === 1'b1) begin
          if (m_exp.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_output: periodo=%0d with no average expected", periodo);
          end else begin
            check("periodo", periodo, m_exp.pop_front());
            check("silence_at_output", silence, m_silence);
          end
        end
        pv = periodo_valid;
        pr = periodo_ready;
        pp = periodo;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK_IN);
      #1;
      if (rand_ready) periodo_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    int base;
    RST_N = 1'b1; enable = 1'b0; meas_done = 1'b0; meas_periodo = '0;
    periodo_ready = 1'b1; rand_ready = 1'b0;
    m_rej = 0; m_silence = 1'b0; n_checks = 0; n_err = 0; n_starts = 0;
    #1 RST_N = 1'b0;
    #1;
    check("rst_periodo", periodo, 0);
    check("rst_valid", periodo_valid, 1'b0);
    check("rst_meas_start", meas_start, 1'b0);
    check("rst_silence", silence, 1'b0);
    check("rst_reject", reject_count, 0);
    @(negedge CLK_IN);
    #2 RST_N = 1'b1;
    repeat (2) @(negedge CLK_IN);
    check("idle_no_start", n_starts, 0);
    #2 enable = 1'b1;

    // Plain average, one-cycle valid, four starts.
    feed(100, 3); feed(102, 0); feed(98, 7); feed(101, 2);
    check("s1_periodo", periodo, 100);
    check("s1_starts", n_starts, 4);
    base = n_starts;
    @(negedge CLK_IN);
    check("s1_valid_one_cycle", periodo_valid, 1'b0);
    check("s1_restart", meas_start, 1'b1);

    // Out-of-range samples are counted and skipped.
    feed(100, 1); feed(10, 0); feed(100, 2); feed(300000, 4); feed(100, 0); feed(100, 5);
    check("s2_starts", n_starts - base, 6);
    check("s2_reject", reject_count, 2);
    check("s2_periodo", periodo, 100);

    // Silence, automatic retry, silence cleared by the next average.
    @(negedge CLK_IN);
    stay_silent();
    check("s3_silence_set", silence, 1'b1);
    feed(50, 1); feed(50, 1); feed(50, 1); feed(50, 1);
    check("s3_periodo", periodo, 50);
    check("s3_silence_clear", silence, 1'b0);

    // Backpressure; the last done arrives on the final WAIT cycle and still wins.
    @(posedge CLK_IN);
    #1 periodo_ready = 1'b0;
    feed(70, 2); feed(70, 2); feed(70, 2); feed(80, TMO - 1);
    base = n_starts;
    repeat (10) begin
      @(negedge CLK_IN);
      check("s4_valid_held", periodo_valid, 1'b1);
      check("s4_periodo_held", periodo, 72);
    end
    check("s4_no_start", n_starts, base);
    check("s4_no_silence", silence, 1'b0);
    @(posedge CLK_IN);
    #1 periodo_ready = 1'b1;
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    check("s4_valid_drop", periodo_valid, 1'b0);
    check("s4_restart", meas_start, 1'b1);

    // Drop enable mid-group; late done pulses are ignored and the partial sum discarded.
    feed(300, 1); feed(300, 4);
    wait_start();
    @(posedge CLK_IN);
    @(posedge CLK_IN);
    #1;
    enable = 1'b0; meas_done = 1'b1; meas_periodo = 300;
    @(posedge CLK_IN);
    #1 meas_done = 1'b0;
    m_part.delete();
    base = n_starts;
    @(posedge CLK_IN);
    #1; meas_done = 1'b1; meas_periodo = 5;
    @(posedge CLK_IN);
    #1 meas_done = 1'b0;
    repeat (4) @(negedge CLK_IN);
    check("s5_idle_no_start", n_starts, base);
    check("s5_reject_same", reject_count, m_rej);
    check("s5_no_valid", periodo_valid, 1'b0);
    #2 enable = 1'b1;
    feed(200, 0); feed(200, 1); feed(200, 2); feed(200, 3);
    check("s5_periodo", periodo, 200);

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 8)       stay_silent();
      else if (r < 13) feed(rand_period(), TMO - 1);
      else             feed(rand_period(), $urandom_range(0, 12));
    end
    #2 rand_ready = 1'b0;
    periodo_ready = 1'b1;
    while (m_part.size() != 0) feed(100, 0);

    // Reject counter saturates at 255.
    for (int i = 0; i < 260; i++) feed((i % 2) ? 5 : 250000, 0);
    check("sat_reject", reject_count, 255);

    // Asynchronous reset in the middle of an output handshake.
    #2 periodo_ready = 1'b0;
    feed(100, 0); feed(100, 1); feed(100, 0); feed(100, 2);
    check("r_periodo_before", periodo, 100);
    repeat (3) @(negedge CLK_IN);
    #2 RST_N = 1'b0;
    #1;
    check("r_periodo", periodo, 0);
    check("r_valid", periodo_valid, 1'b0);
    check("r_silence", silence, 1'b0);
    check("r_reject", reject_count, 0);
    check("r_meas_start", meas_start, 1'b0);
    m_exp.delete(); m_part.delete(); m_rej = 0; m_silence = 1'b0;
    enable = 1'b0;
    periodo_ready = 1'b1;
    @(negedge CLK_IN);
    #2 RST_N = 1'b1;
    base = n_starts;
    repeat (4) @(negedge CLK_IN);
    check("r_idle_no_start", n_starts, base);
    #2 enable = 1'b1;
    @(negedge CLK_IN);
    check("r_start_after_enable", meas_start, 1'b1);
    #2 enable = 1'b0;
    repeat (3) @(negedge CLK_IN);
    finish_run();
  end

endmodule
